// File: rtl/mem_arbiter_if.sv
// Client/memory bus bundle for mem_arbiter.
// slave  : arbiter side (takes client requests, drives memory strobes)
// master : environment side (clients and memory model)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        vga_state;

  logic              cpu_write;
  logic              cpu_read;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [3:0]        cpu_sel;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_en;

  logic              uart_write;
  logic [ADDR_W-1:0] uart_adr;
  logic [DATA_W-1:0] uart_wdata;
  logic [3:0]        uart_sel;
  logic              uart_ack;
  logic              uart_en;

  logic              vga_read;
  logic [ADDR_W-1:0] vga_adr;
  logic [3:0]        vga_sel;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_ack;

  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_busy;

  logic              timeout_err;

  modport slave (
    input  vga_state,
    input  cpu_write, cpu_read, cpu_adr, cpu_wdata, cpu_sel,
    output cpu_rdata, cpu_ack, cpu_en,
    input  uart_write, uart_adr, uart_wdata, uart_sel,
    output uart_ack, uart_en,
    input  vga_read, vga_adr, vga_sel,
    output vga_rdata, vga_ack,
    output mem_write, mem_read, mem_adr, mem_wdata, mem_sel,
    input  mem_rdata, mem_busy,
    output timeout_err
  );

  modport master (
    output vga_state,
    output cpu_write, cpu_read, cpu_adr, cpu_wdata, cpu_sel,
    input  cpu_rdata, cpu_ack, cpu_en,
    output uart_write, uart_adr, uart_wdata, uart_sel,
    input  uart_ack, uart_en,
    output vga_read, vga_adr, vga_sel,
    input  vga_rdata, vga_ack,
    input  mem_write, mem_read, mem_adr, mem_wdata, mem_sel,
    output mem_rdata, mem_busy,
    input  timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between CPU, UART and VGA.
// One transaction at a time through IDLE -> ISSUE -> WAIT -> RESP.
// VGA wins whenever its display window is not INACTIVE; CPU and UART
// alternate round-robin only while VGA is INACTIVE.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a mem_busy watchdog in WAIT.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_UART, OWN_VGA} owner_t;

  state_t            state, state_nx;
  owner_t            owner, grant;
  logic              rr_uart;        // 0: CPU next in line, 1: UART next in line
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_adr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_sel;
  logic              grant_wr;
  logic [ADDR_W-1:0] grant_adr;
  logic [DATA_W-1:0] grant_wdata;
  logic [3:0]        grant_sel;
  logic [DATA_W-1:0] cpu_rdata_q, vga_rdata_q;
  logic              cpu_req, uart_req, vga_inactive, capture;

  assign cpu_req      = bus.cpu_write | bus.cpu_read;
  assign uart_req     = bus.uart_write;
  assign vga_inactive = (bus.vga_state == 2'b00);
  // Memory answered this cycle; the owner's read data is taken now.
  assign capture      = (state == WAIT) && !bus.mem_busy;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit, tmo_q;

  // Last allowed busy cycle of WAIT has been reached and memory is still busy.
  assign timeout_hit = (state == WAIT) && bus.mem_busy &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                    wait_cnt <= '0;
  end

  // Error flag lines up with the RESP cycle of a timed-out transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= 1'b0;
    else     tmo_q <= timeout_hit;
  end

  assign bus.timeout_err = tmo_q;
`else
  // Watchdog compiled out; the expression is constant 0 but keeps the
  // parameter referenced so both builds share one parameter list.
  assign bus.timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state and grant selection.
  always_comb begin
    state_nx    = state;
    grant       = OWN_NONE;
    grant_wr    = 1'b0;
    grant_adr   = '0;
    grant_wdata = '0;
    grant_sel   = '0;
    unique case (state)
      IDLE: begin
        if (!bus.mem_busy) begin
          if (!vga_inactive && bus.vga_read)
            grant = OWN_VGA;
          else if (vga_inactive) begin
            if (cpu_req && (!uart_req || !rr_uart)) grant = OWN_CPU;
            else if (uart_req)                      grant = OWN_UART;
          end
        end
        if (grant != OWN_NONE) state_nx = ISSUE;
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (!bus.mem_busy) state_nx = RESP;
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_hit) state_nx = RESP;
`endif
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    unique case (grant)
      OWN_CPU: begin
        grant_wr    = bus.cpu_write;      // both strobes high counts as a write
        grant_adr   = bus.cpu_adr;
        grant_wdata = bus.cpu_write ? bus.cpu_wdata : '0;
        grant_sel   = bus.cpu_sel;
      end
      OWN_UART: begin
        grant_wr    = 1'b1;
        grant_adr   = bus.uart_adr;
        grant_wdata = bus.uart_wdata;
        grant_sel   = bus.uart_sel;
      end
      OWN_VGA: begin
        grant_wr    = 1'b0;
        grant_adr   = bus.vga_adr;
        grant_sel   = bus.vga_sel;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Latch owner and request fields at grant; owner released after RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_NONE;
      lat_wr    <= 1'b0;
      lat_adr   <= '0;
      lat_wdata <= '0;
      lat_sel   <= '0;
    end else if (grant != OWN_NONE) begin
      owner     <= grant;
      lat_wr    <= grant_wr;
      lat_adr   <= grant_adr;
      lat_wdata <= grant_wdata;
      lat_sel   <= grant_sel;
    end else if (state == RESP) begin
      owner     <= OWN_NONE;
    end
  end

  // Round-robin pointer flips to the other CPU/UART client after its RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_uart <= 1'b0;
    else if (state == RESP) begin
      if (owner == OWN_CPU)       rr_uart <= 1'b1;
      else if (owner == OWN_UART) rr_uart <= 1'b0;
    end
  end

  // Per-client read data; only updated by that client's own completing read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      if (capture && !lat_wr) begin
        if (owner == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
        if (owner == OWN_VGA) vga_rdata_q <= bus.mem_rdata;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      if (timeout_hit) begin
        if (owner == OWN_CPU) cpu_rdata_q <= '0;
        if (owner == OWN_VGA) vga_rdata_q <= '0;
      end
`endif
    end
  end

  // Outputs decode from registered state only, so no input-to-output paths.
  assign bus.mem_write = (state == ISSUE) &&  lat_wr;
  assign bus.mem_read  = (state == ISSUE) && !lat_wr;
  assign bus.mem_adr   = (state == ISSUE || state == WAIT) ? lat_adr   : '0;
  assign bus.mem_wdata = (state == ISSUE || state == WAIT) ? lat_wdata : '0;
  assign bus.mem_sel   = (state == ISSUE || state == WAIT) ? lat_sel   : '0;

  assign bus.cpu_en    = (owner == OWN_CPU);
  assign bus.uart_en   = (owner == OWN_UART);
  assign bus.cpu_ack   = (state == RESP) && (owner == OWN_CPU);
  assign bus.uart_ack  = (state == RESP) && (owner == OWN_UART);
  assign bus.vga_ack   = (state == RESP) && (owner == OWN_VGA);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vga_rdata = vga_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a queue scoreboard: stimulus pushes the
// expected memory issue and client ack, a negedge monitor pops and compares.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CPU = 0, UART = 1, VGA = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            client;
    bit            chk_rd;
    logic [DW-1:0] rdata;
    int            cyc;
    bit            tmo;
  } ack_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic [3:0]    sel;
    int            cyc;
  } iss_t;

  ack_t ack_q[$];
  iss_t iss_q[$];
  int   n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_iss(input bit wr, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                          input logic [3:0] sel, input int c);
    iss_t e;
    e.wr = wr; e.adr = adr; e.wdata = wd; e.sel = sel; e.cyc = c;
    iss_q.push_back(e);
  endtask

  task automatic push_ack(input int client, input bit chk_rd, input logic [DW-1:0] rd,
                          input int c, input bit tmo);
    ack_t e;
    e.client = client; e.chk_rd = chk_rd; e.rdata = rd; e.cyc = c; e.tmo = tmo;
    ack_q.push_back(e);
  endtask

  // Monitor: compares every memory strobe and every ack against the queues.
  ack_t       ea;
  iss_t       ei;
  logic [2:0] acks;
  always @(negedge clk) begin
    if (!rst) begin
      acks = {bus.vga_ack, bus.uart_ack, bus.cpu_ack};
      if (bus.cpu_en && bus.uart_en) chk("en_onehot", 64'(1), 64'(0));
      if (bus.mem_write || bus.mem_read) begin
        if (iss_q.size() == 0)
          chk("unexpected_strobe", 64'({bus.mem_write, bus.mem_read}), 64'(0));
        else begin
          ei = iss_q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(ei.cyc));
          chk("issue_strobes", 64'({bus.mem_write, bus.mem_read}), ei.wr ? 64'(2) : 64'(1));
          chk("issue_adr", 64'(bus.mem_adr), 64'(ei.adr));
          chk("issue_sel", 64'(bus.mem_sel), 64'(ei.sel));
          if (ei.wr) chk("issue_wdata", 64'(bus.mem_wdata), 64'(ei.wdata));
        end
      end
      if (acks != 3'b000) begin
        if (ack_q.size() == 0)
          chk("unexpected_ack", 64'(acks), 64'(0));
        else begin
          ea = ack_q.pop_front();
          chk("ack_client", 64'(acks), 64'(3'b001 << ea.client));
          chk("ack_cycle", 64'(cyc), 64'(ea.cyc));
          chk("ack_timeout_err", 64'(bus.timeout_err), 64'(ea.tmo));
          chk("resp_mem_quiet", 64'({bus.mem_write, bus.mem_read, |bus.mem_adr,
                                     |bus.mem_wdata, |bus.mem_sel}), 64'(0));
          if (ea.client == CPU)  chk("resp_cpu_en", 64'(bus.cpu_en), 64'(1));
          if (ea.client == UART) chk("resp_uart_en", 64'(bus.uart_en), 64'(1));
          if (ea.chk_rd && ea.client == CPU) chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(ea.rdata));
          if (ea.chk_rd && ea.client == VGA) chk("vga_rdata", 64'(bus.vga_rdata), 64'(ea.rdata));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Advance to cycle n (just after its rising edge).
  task automatic at(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic idle_inputs();
    bus.vga_state = 2'b00;
    bus.cpu_write = 0; bus.cpu_read = 0; bus.cpu_adr = '0; bus.cpu_wdata = '0; bus.cpu_sel = '0;
    bus.uart_write = 0; bus.uart_adr = '0; bus.uart_wdata = '0; bus.uart_sel = '0;
    bus.vga_read = 0; bus.vga_adr = '0; bus.vga_sel = '0;
    bus.mem_rdata = '0; bus.mem_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    step(); step();
    rst = 0;
    step();
  endtask

  // Bounded wait for the scoreboard to empty; leftovers are failures.
  task automatic drain(input int budget);
    int k = 0;
    while ((ack_q.size() != 0 || iss_q.size() != 0) && k < budget) begin
      step(); k++;
    end
    chk("pending_acks", 64'(ack_q.size()), 64'(0));
    chk("pending_issues", 64'(iss_q.size()), 64'(0));
    ack_q.delete(); iss_q.delete();
    repeat (3) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, 64'({bus.cpu_rdata, bus.vga_rdata}), 64'(0));
    chk({tag, "_ctl"}, 64'({bus.cpu_ack, bus.cpu_en, bus.uart_ack, bus.uart_en, bus.vga_ack,
                           bus.mem_write, bus.mem_read, bus.timeout_err}), 64'(0));
    chk({tag, "_mem"}, 64'({bus.mem_adr, bus.mem_wdata}), 64'(0));
    chk({tag, "_sel"}, 64'(bus.mem_sel), 64'(0));
  endtask

  int   n;
  logic seen, held;

  initial begin
    // Reset with every request asserted.
    rst = 1; idle_inputs();
    bus.vga_state = 2'b10; bus.vga_read = 1; bus.vga_adr = 'h10; bus.vga_sel = 4'hF;
    bus.cpu_write = 1; bus.cpu_read = 1; bus.cpu_adr = 'h20; bus.cpu_wdata = 'h30; bus.cpu_sel = 4'hF;
    bus.uart_write = 1; bus.uart_adr = 'h40; bus.uart_wdata = 'h50; bus.uart_sel = 4'hF;
    bus.mem_rdata = 'hFFFF;
    step(); step();
    @(negedge clk);
    chk_all_zero("reset");
    // Release with memory busy: nothing may be granted.
    @(posedge clk); #1;
    bus.mem_busy = 1; rst = 0;
    seen = 0;
    repeat (10) begin @(negedge clk); seen |= bus.cpu_en | bus.uart_en | bus.mem_read | bus.mem_write; end
    chk("busy_blocks_grant", 64'(seen), 64'(0));

    // VGA priority over held CPU and UART writes.
    do_reset();
    n = cyc;
    bus.vga_state = 2'b10; bus.vga_read = 1; bus.vga_adr = 'h789; bus.vga_sel = 4'hF;
    bus.cpu_write = 1; bus.cpu_adr = 'h123; bus.cpu_wdata = 'hCCCC; bus.cpu_sel = 4'hF;
    bus.uart_write = 1; bus.uart_adr = 'h456; bus.uart_wdata = 'hAAAA; bus.uart_sel = 4'h3;
    bus.mem_rdata = 'h911;
    push_iss(0, 'h789, '0, 4'hF, n + 1);
    push_ack(VGA, 1, 'h911, n + 3, 0);
    seen = 0;
    repeat (3) begin @(negedge clk); seen |= bus.cpu_en | bus.uart_en; end
    at(n + 3); bus.vga_read = 0;
    repeat (5) begin @(negedge clk); seen |= bus.cpu_en | bus.uart_en; end
    chk("vga_excludes_cpu_uart", 64'(seen), 64'(0));
    step(); bus.cpu_write = 0; bus.uart_write = 0;
    drain(20);

    // Round-robin between continuously held CPU and UART writes.
    do_reset();
    n = cyc;
    bus.cpu_write = 1; bus.cpu_adr = 'h123; bus.cpu_wdata = 'hCCCC; bus.cpu_sel = 4'hF;
    bus.uart_write = 1; bus.uart_adr = 'h456; bus.uart_wdata = 'hAAAA; bus.uart_sel = 4'h3;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_iss(1, 'h123, 'hCCCC, 4'hF, n + 1 + 4 * k);
      else            push_iss(1, 'h456, 'hAAAA, 4'h3, n + 1 + 4 * k);
      push_ack((k % 2 == 0) ? CPU : UART, 0, '0, n + 3 + 4 * k, 0);
    end
    at(n + 14); bus.cpu_write = 0; bus.uart_write = 0;
    drain(30);

    // Stalled CPU read, then a write that must leave cpu_rdata alone.
    do_reset();
    n = cyc;
    bus.cpu_read = 1; bus.cpu_adr = 'h111; bus.cpu_sel = 4'h7;
    push_iss(0, 'h111, '0, 4'h7, n + 1);
    push_ack(CPU, 1, 'hCAB, n + 8, 0);
    at(n + 1); bus.mem_busy = 1; bus.mem_rdata = 'hBAD;
    @(negedge clk);
    held = 1;
    repeat (5) begin @(negedge clk); held &= (bus.mem_adr == 'h111) && !bus.mem_read && bus.cpu_en; end
    chk("stall_adr_hold", 64'(held), 64'(1));
    at(n + 7); bus.mem_busy = 0; bus.mem_rdata = 'hCAB;
    at(n + 8); bus.cpu_read = 0;
    drain(20);
    n = cyc;
    bus.cpu_write = 1; bus.cpu_adr = 'h10; bus.cpu_wdata = 'h5; bus.cpu_sel = 4'hF;
    bus.mem_rdata = 'hDEAD;
    push_iss(1, 'h10, 'h5, 4'hF, n + 1);
    push_ack(CPU, 1, 'hCAB, n + 3, 0);
    at(n + 3); bus.cpu_write = 0;
    drain(20);

    // VGA window opens during a CPU read; UART waits until INACTIVE.
    do_reset();
    n = cyc;
    bus.cpu_read = 1; bus.cpu_adr = 'h222; bus.cpu_sel = 4'h3;
    bus.uart_write = 1; bus.uart_adr = 'h333; bus.uart_wdata = 'h55; bus.uart_sel = 4'hF;
    push_iss(0, 'h222, '0, 4'h3, n + 1);
    push_ack(CPU, 1, 'h77, n + 5, 0);
    at(n + 1); bus.mem_busy = 1; bus.vga_state = 2'b01;
    at(n + 4); bus.mem_busy = 0; bus.mem_rdata = 'h77;
    at(n + 5); bus.cpu_read = 0;
    at(n + 8); bus.vga_read = 1; bus.vga_adr = 'h400; bus.vga_sel = 4'h1; bus.mem_rdata = 'h99;
    push_iss(0, 'h400, '0, 4'h1, n + 9);
    push_ack(VGA, 1, 'h99, n + 11, 0);
    at(n + 11); bus.vga_read = 0;
    push_iss(1, 'h333, 'h55, 4'hF, n + 14);
    push_ack(UART, 0, '0, n + 16, 0);
    at(n + 13); bus.vga_state = 2'b00;
    at(n + 16); bus.uart_write = 0;
    drain(20);

    // Reset during WAIT aborts without an ack.
    do_reset();
    n = cyc;
    bus.cpu_write = 1; bus.cpu_adr = 'h500; bus.cpu_wdata = 'h1; bus.cpu_sel = 4'hF;
    push_iss(1, 'h500, 'h1, 4'hF, n + 1);
    at(n + 1); bus.mem_busy = 1;
    at(n + 4); rst = 1;
    @(negedge clk);
    chk_all_zero("abort");
    at(n + 6); rst = 0; bus.cpu_write = 0; bus.mem_busy = 0;
    repeat (6) step();
    drain(5);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory stuck busy: watchdog completes the read with zero data.
    do_reset();
    n = cyc;
    bus.cpu_read = 1; bus.cpu_adr = 'h600; bus.cpu_sel = 4'hF;
    push_iss(0, 'h600, '0, 4'hF, n + 1);
    push_ack(CPU, 1, '0, n + 66, 1);
    at(n + 1); bus.mem_busy = 1; bus.mem_rdata = 'hFFFF;
    at(n + 66); bus.cpu_read = 0;
    at(n + 67); bus.mem_busy = 0;
    drain(100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
